// File: rtl/rx_deframer_if.sv
// Bit input and reassembled byte stream of the receive deframer.
// The deframer drives the byte stream, so it takes the master side.
interface rx_deframer_if;
    logic       rx_bit;
    logic       rx_bit_vld;
    logic [7:0] data_tdata;
    logic       data_tvalid;
    logic       data_tuser;
    logic       data_tlast;

    modport master (
        input  rx_bit,
        input  rx_bit_vld,
        output data_tdata,
        output data_tvalid,
        output data_tuser,
        output data_tlast
    );

    modport slave (
        output rx_bit,
        output rx_bit_vld,
        input  data_tdata,
        input  data_tvalid,
        input  data_tuser,
        input  data_tlast
    );
endinterface

// File: rtl/rx_deframer.sv
// Receive deframer: hunts for the sync word in either polarity, reads the
// length byte and reassembles the payload into a byte stream.
module rx_deframer #(
    parameter logic [15:0] SYNC_WORD    = 16'hEB90,
    parameter int          SYNC_ERR_MAX = 1,
    parameter int          TIMEOUT      = 64
) (
    input  logic          clk_1M024,
    input  logic          rst_n_1M024,
    rx_deframer_if.master bus,
    output logic          sync_locked,
    output logic          phase_inv,
    output logic          frame_err
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_t;

    state_t              state, state_nxt;
    logic [15:0]         hunt_sr, hunt_sr_nxt;
    logic [4:0]          fill, fill_nxt;
    logic [7:0]          byte_sr, byte_sr_nxt;
    logic [2:0]          bit_cnt, bit_cnt_nxt;
    logic [7:0]          remaining, remaining_nxt;
    logic                first_byte, first_byte_nxt;
    logic [IDLE_W-1:0]   idle_cnt, idle_cnt_nxt;
    logic                phase_inv_nxt;
    logic                frame_err_nxt;
    logic [7:0]          tdata, tdata_nxt;
    logic                tvalid, tvalid_nxt;
    logic                tuser, tuser_nxt;
    logic                tlast, tlast_nxt;

    logic [15:0]         hunt_word;
    logic [4:0]          d0, d1;
    logic                bit_fix;
    logic [7:0]          byte_word;
    logic [7:0]          rem_dec;
    logic [IDLE_W-1:0]   idle_inc;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        hunt_word = {hunt_sr[14:0], bus.rx_bit};
        d0        = popcount16(hunt_word ^ SYNC_WORD);
        d1        = popcount16(hunt_word ^ ~SYNC_WORD);
        bit_fix   = bus.rx_bit ^ phase_inv;
        byte_word = {byte_sr[6:0], bit_fix};
        rem_dec   = remaining - 1'b1;
        idle_inc  = (idle_cnt == IDLE_W'(TIMEOUT)) ? idle_cnt : idle_cnt + 1'b1;

        state_nxt      = state;
        hunt_sr_nxt    = hunt_sr;
        fill_nxt       = fill;
        byte_sr_nxt    = byte_sr;
        bit_cnt_nxt    = bit_cnt;
        remaining_nxt  = remaining;
        first_byte_nxt = first_byte;
        idle_cnt_nxt   = idle_cnt;
        phase_inv_nxt  = phase_inv;
        frame_err_nxt  = 1'b0;
        tdata_nxt      = 8'h00;
        tvalid_nxt     = 1'b0;
        tuser_nxt      = 1'b0;
        tlast_nxt      = 1'b0;

        if (bus.rx_bit_vld) begin
            hunt_sr_nxt = hunt_word;
        end

        case (state)
            HUNT: begin
                bit_cnt_nxt  = '0;
                idle_cnt_nxt = '0;
                if (bus.rx_bit_vld) begin
                    if (fill != 5'd16) begin
                        fill_nxt = fill + 1'b1;
                    end
                    // Fill of 15 before this shift means the word is 16 fresh bits.
                    if (fill >= 5'd15) begin
                        if (d0 <= 5'(SYNC_ERR_MAX)) begin
                            phase_inv_nxt = 1'b0;
                            state_nxt     = LEN;
                        end else if (d1 <= 5'(SYNC_ERR_MAX)) begin
                            phase_inv_nxt = 1'b1;
                            state_nxt     = LEN;
                        end
                    end
                end
            end

            LEN, PAYLOAD: begin
                if (bus.rx_bit_vld) begin
                    idle_cnt_nxt = '0;
                    byte_sr_nxt  = byte_word;
                    bit_cnt_nxt  = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        if (state == LEN) begin
                            if (byte_word == 8'h00) begin
                                frame_err_nxt = 1'b1;
                                state_nxt     = HUNT;
                                fill_nxt      = '0;
                            end else begin
                                remaining_nxt  = byte_word;
                                first_byte_nxt = 1'b1;
                                state_nxt      = PAYLOAD;
                            end
                        end else begin
                            tvalid_nxt     = 1'b1;
                            tdata_nxt      = byte_word;
                            tuser_nxt      = first_byte;
                            first_byte_nxt = 1'b0;
                            remaining_nxt  = rem_dec;
                            if (rem_dec == 8'h00) begin
                                tlast_nxt = 1'b1;
                                state_nxt = HUNT;
                                fill_nxt  = '0;
                            end
                        end
                    end
                end else begin
                    idle_cnt_nxt = idle_inc;
                    // Abort drops any half-built byte; no tlast for this frame.
                    if (idle_inc == IDLE_W'(TIMEOUT)) begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = HUNT;
                        fill_nxt      = '0;
                        bit_cnt_nxt   = '0;
                        idle_cnt_nxt  = '0;
                    end
                end
            end

            default: begin
                state_nxt = HUNT;
                fill_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
        if (!rst_n_1M024) begin
            state      <= HUNT;
            hunt_sr    <= '0;
            fill       <= '0;
            byte_sr    <= '0;
            bit_cnt    <= '0;
            remaining  <= '0;
            first_byte <= 1'b0;
            idle_cnt   <= '0;
            phase_inv  <= 1'b0;
            frame_err  <= 1'b0;
            tdata      <= '0;
            tvalid     <= 1'b0;
            tuser      <= 1'b0;
            tlast      <= 1'b0;
        end else begin
            state      <= state_nxt;
            hunt_sr    <= hunt_sr_nxt;
            fill       <= fill_nxt;
            byte_sr    <= byte_sr_nxt;
            bit_cnt    <= bit_cnt_nxt;
            remaining  <= remaining_nxt;
            first_byte <= first_byte_nxt;
            idle_cnt   <= idle_cnt_nxt;
            phase_inv  <= phase_inv_nxt;
            frame_err  <= frame_err_nxt;
            tdata      <= tdata_nxt;
            tvalid     <= tvalid_nxt;
            tuser      <= tuser_nxt;
            tlast      <= tlast_nxt;
        end
    end

    assign sync_locked      = (state != HUNT);
    assign bus.data_tdata   = tdata;
    assign bus.data_tvalid  = tvalid;
    assign bus.data_tuser   = tuser;
    assign bus.data_tlast   = tlast;

endmodule

// File: tb/tb_rx_deframer.sv
// Directed bench for rx_deframer: clean, inverted, sync-error, zero-length,
// timeout and reset/random-prefix frames against hand-computed bytes.
module tb_rx_deframer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sync_locked, phase_inv, frame_err;

    always #5 clk = ~clk;

    rx_deframer_if bus ();

    rx_deframer dut (
        .clk_1M024   (clk),
        .rst_n_1M024 (rst_n),
        .bus         (bus),
        .sync_locked (sync_locked),
        .phase_inv   (phase_inv),
        .frame_err   (frame_err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int vld_cyc = 0;
    int strobe_cyc = 0;
    int err_cnt = 0;
    int zero_viol = 0;
    logic [9:0] got_q[$];

    // Byte log entry: {tuser, tlast, tdata}
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (bus.data_tvalid) begin
            got_q.push_back({bus.data_tuser, bus.data_tlast, bus.data_tdata});
            strobe_cyc = cyc;
        end else if ({bus.data_tdata, bus.data_tuser, bus.data_tlast} != 10'h000) begin
            zero_viol++;
        end
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] q_at(input int i);
        if (i < got_q.size()) return {22'h0, got_q[i]};
        return 32'hDEAD;
    endfunction

    task automatic clear_log();
        got_q.delete();
        err_cnt = 0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        @(negedge clk);
        bus.rx_bit     = b;
        bus.rx_bit_vld = 1'b1;
        vld_cyc        = cyc;
        @(negedge clk);
        bus.rx_bit_vld = 1'b0;
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n, input int gap, input logic inv);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i] ^ inv, gap);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " tvalid"}, {31'h0, bus.data_tvalid}, 32'h0);
        check({tag, " tdata"},  {24'h0, bus.data_tdata},  32'h0);
        check({tag, " tuser"},  {31'h0, bus.data_tuser},  32'h0);
        check({tag, " tlast"},  {31'h0, bus.data_tlast},  32'h0);
        check({tag, " locked"}, {31'h0, sync_locked},     32'h0);
        check({tag, " phase"},  {31'h0, phase_inv},       32'h0);
        check({tag, " ferr"},   {31'h0, frame_err},       32'h0);
    endtask

    logic [39:0] prefix;
    logic [55:0] stream;
    logic [15:0] win;
    logic        ok;

    initial begin
        bus.rx_bit     = 1'b0;
        bus.rx_bit_vld = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("post reset");

        // Clean frame, one bit every 16 cycles
        clear_log();
        send_bits(64'hEB90 >> 1, 15, 16, 1'b0);
        check("clean pre-lock", {31'h0, sync_locked}, 32'h0);
        send_bit(1'b0, 16);
        check("clean lock", {31'h0, sync_locked}, 32'h1);
        check("clean phase", {31'h0, phase_inv}, 32'h0);
        send_bits(64'h03A55AFF, 32, 16, 1'b0);
        check("clean count", got_q.size(), 3);
        check("clean b0", q_at(0), 32'h2A5);
        check("clean b1", q_at(1), 32'h05A);
        check("clean b2", q_at(2), 32'h1FF);
        check("clean latency", strobe_cyc - vld_cyc, 1);
        check("clean unlock", {31'h0, sync_locked}, 32'h0);
        check("clean ferr", err_cnt, 0);

        // Inverted polarity
        clear_log();
        send_bits(64'hEB90021234, 40, 4, 1'b1);
        check("inv count", got_q.size(), 2);
        check("inv b0", q_at(0), 32'h212);
        check("inv b1", q_at(1), 32'h134);
        check("inv phase held", {31'h0, phase_inv}, 32'h1);
        check("inv unlock", {31'h0, sync_locked}, 32'h0);

        // One sync error accepted
        clear_log();
        send_bits(64'hEB9101C3, 32, 4, 1'b0);
        check("err1 count", got_q.size(), 1);
        check("err1 b0", q_at(0), 32'h3C3);
        check("err1 phase", {31'h0, phase_inv}, 32'h0);
        check("err1 ferr", err_cnt, 0);

        // Two sync errors rejected
        clear_log();
        send_bits(64'hEB93, 16, 4, 1'b0);
        repeat (4) @(negedge clk);
        check("err2 locked", {31'h0, sync_locked}, 32'h0);
        check("err2 count", got_q.size(), 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero length, then a normal frame
        clear_log();
        send_bits(64'hEB9000, 24, 4, 1'b0);
        repeat (2) @(negedge clk);
        check("zlen ferr", err_cnt, 1);
        check("zlen count", got_q.size(), 0);
        check("zlen locked", {31'h0, sync_locked}, 32'h0);
        clear_log();
        send_bits(64'hEB90017E, 32, 4, 1'b0);
        check("zlen next b0", q_at(0), 32'h37E);
        check("zlen next count", got_q.size(), 1);

        // Timeout: 63 idle cycles tolerated, then an abort
        clear_log();
        send_bits(64'hEB9004, 24, 4, 1'b0);
        send_bits(64'h11, 8, 64, 1'b0);
        check("tmo gap63 locked", {31'h0, sync_locked}, 32'h1);
        send_bits(64'h22, 8, 4, 1'b0);
        send_bits(64'h3, 2, 4, 1'b0);
        repeat (70) @(negedge clk);
        check("tmo count", got_q.size(), 2);
        check("tmo b0", q_at(0), 32'h211);
        check("tmo b1", q_at(1), 32'h022);
        check("tmo ferr", err_cnt, 1);
        check("tmo locked", {31'h0, sync_locked}, 32'h0);
        clear_log();
        send_bits(64'hEB90015A, 32, 4, 1'b0);
        check("tmo next b0", q_at(0), 32'h35A);
        check("tmo next count", got_q.size(), 1);

        // Reset mid-payload
        clear_log();
        send_bits(64'hEB9003AB5, 36, 4, 1'b0);
        check("rst first byte", q_at(0), 32'h2AB);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst locked", {31'h0, sync_locked}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("mid reset");
        check("rst no ferr", err_cnt, 0);

        // Random prefix free of accidental sync windows
        ok = 1'b0;
        for (int a = 0; a < 200 && !ok; a++) begin
            prefix = {$urandom, $urandom};
            stream = {prefix, 16'hEB90};
            ok = 1'b1;
            for (int e = 15; e < 55; e++) begin
                win = stream[70 - e -: 16];
                if ($countones(win ^ 16'hEB90) <= 1 || $countones(win ^ 16'h146F) <= 1) ok = 1'b0;
            end
        end
        check("prefix found", {31'h0, ok}, 32'h1);
        clear_log();
        send_bits({24'h0, prefix}, 40, 4, 1'b0);
        check("prefix no lock", {31'h0, sync_locked}, 32'h0);
        send_bits(64'hEB9002AA55, 40, 4, 1'b0);
        check("prefix count", got_q.size(), 2);
        check("prefix b0", q_at(0), 32'h2AA);
        check("prefix b1", q_at(1), 32'h155);
        check("prefix ferr", err_cnt, 0);

        check("idle outputs zero", zero_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
